// File: rtl/prom_word_loader.sv
// -----------------------------------------------------------------------------
// prom_word_loader
//
// Captures PROM bytes on the sequencer's byte-lane strobes, assembles them into
// 16-bit words (ECC=0) or 48-bit words (ECC=1), optionally checks a per-block
// CRC-16-CCITT, writes data words to the configuration memory and reports load
// status when the sequencer signals transfer done.
//
// Handshake: the sequencer is the only initiator. LDBn and INC are single-cycle
// qualifiers with no backpressure. The loader absorbs an INC every 2 cycles,
// and WE is a one-cycle write pulse that the memory must always accept.
//
// Ports
//   CLK, RST         clock, asynchronous active-high reset
//   PROM_DATA[7:0]   PROM byte bus, valid whenever any LDBn is high
//   LDB0..LDB5       byte-lane load strobes
//   INC              last byte of the current word is on PROM_DATA
//   RST_CNT          start-of-transfer clear; latches ECC and CRC
//   XFER_DONE        transfer complete
//   ECC, CRC         word-format and CRC-mode selects
//   WE, WADDR, WDATA registered memory write port
//   LOAD_DONE        one-cycle completion pulse
//   LOAD_OK          status of the last load (level)
//   CRC_ERR, ERR_BLKS sticky CRC failure flag and saturating failed-block count
//   OVF              sticky: INC arrived after the last expected word
//   DBG_STATE[2:0]   current FSM state (IDLE=0 DATA=1 CRC0=2 CRC1=3 FULL=4 DONE=5)
// -----------------------------------------------------------------------------
module prom_word_loader #(
  parameter logic [8:0] MAX_WRDS = 9'd34,
  parameter logic [8:0] NMAX     = 9'd10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  PROM_DATA,
  input  logic        LDB0,
  input  logic        LDB1,
  input  logic        LDB2,
  input  logic        LDB3,
  input  logic        LDB4,
  input  logic        LDB5,
  input  logic        INC,
  input  logic        RST_CNT,
  input  logic        XFER_DONE,
  input  logic        ECC,
  input  logic        CRC,
  output logic        WE,
  output logic [8:0]  WADDR,
  output logic [47:0] WDATA,
  output logic        LOAD_DONE,
  output logic        LOAD_OK,
  output logic        CRC_ERR,
  output logic [3:0]  ERR_BLKS,
  output logic        OVF,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_CRC0 = 3'd2,
    S_CRC1 = 3'd3,
    S_FULL = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  logic [7:0]  r_b [0:5];
  logic        r_ecc;
  logic        r_crc_mode;
  logic [8:0]  r_word_in_blk;
  logic [8:0]  r_blk;
  logic [8:0]  r_waddr_cnt;
  logic [15:0] r_crc;
  logic [15:0] r_exp;
  logic        r_we;
  logic [8:0]  r_waddr;
  logic [47:0] r_wdata;
  logic        r_load_done;
  logic        r_load_ok;
  logic        r_crc_err;
  logic [3:0]  r_err_blks;
  logic        r_ovf;

  logic [5:0]  w_ldb;
  logic [7:0]  w_b [0:5];
  logic [15:0] w_word16;
  logic [47:0] w_wdata;
  logic [15:0] w_crc_next;
  logic        w_crc_pass;

  // CRC-16-CCITT, poly 0x1021, MSB first, one 16-bit word per call.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 15; i >= 0; i--) begin
      if (x[15] ^ d[i]) x = {x[14:0], 1'b0} ^ 16'h1021;
      else              x = {x[14:0], 1'b0};
    end
    return x;
  endfunction

  assign w_ldb = {LDB5, LDB4, LDB3, LDB2, LDB1, LDB0};

  // The byte arriving this cycle bypasses its register so the word is
  // complete in the INC cycle itself.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_b[i] = w_ldb[i] ? PROM_DATA : r_b[i];
    end
  end

  assign w_word16   = {w_b[1], w_b[0]};
  assign w_wdata    = r_ecc ? {w_b[5], w_b[4], w_b[3], w_b[2], w_b[1], w_b[0]}
                            : {32'd0, w_word16};
  assign w_crc_next = crc16_step(r_crc, w_word16);
  assign w_crc_pass = (r_exp == r_crc) && (w_word16 == ~r_crc);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < 6; i++) r_b[i] <= 8'd0;
      r_ecc         <= 1'b0;
      r_crc_mode    <= 1'b0;
      r_word_in_blk <= 9'd0;
      r_blk         <= 9'd0;
      r_waddr_cnt   <= 9'd0;
      r_crc         <= 16'hFFFF;
      r_exp         <= 16'd0;
      r_we          <= 1'b0;
      r_waddr       <= 9'd0;
      r_wdata       <= 48'd0;
      r_load_done   <= 1'b0;
      r_load_ok     <= 1'b0;
      r_crc_err     <= 1'b0;
      r_err_blks    <= 4'd0;
      r_ovf         <= 1'b0;
    end else begin
      r_we        <= 1'b0;
      r_load_done <= 1'b0;
      if (RST_CNT) begin
        // Start of a new transfer: LOAD_OK keeps reporting the previous load.
        r_state       <= S_IDLE;
        r_ecc         <= ECC;
        r_crc_mode    <= CRC;
        for (int i = 0; i < 6; i++) r_b[i] <= 8'd0;
        r_word_in_blk <= 9'd0;
        r_blk         <= 9'd0;
        r_waddr_cnt   <= 9'd0;
        r_crc         <= 16'hFFFF;
        r_crc_err     <= 1'b0;
        r_err_blks    <= 4'd0;
        r_ovf         <= 1'b0;
      end else begin
        for (int i = 0; i < 6; i++) begin
          if (w_ldb[i]) r_b[i] <= PROM_DATA;
        end
        if (XFER_DONE && (r_state != S_DONE)) begin
          r_state     <= S_DONE;
          r_load_done <= 1'b1;
          r_load_ok   <= (r_state == S_FULL) && !r_crc_err && !r_ovf;
        end else begin
          case (r_state)
            S_IDLE: r_state <= S_DATA;
            S_DATA: begin
              if (INC) begin
                r_we        <= 1'b1;
                r_waddr     <= r_waddr_cnt;
                r_wdata     <= w_wdata;
                r_waddr_cnt <= r_waddr_cnt + 9'd1;
                r_crc       <= w_crc_next;
                if (r_word_in_blk == MAX_WRDS - 9'd1) begin
                  if (r_crc_mode) begin
                    r_state       <= S_CRC0;
                    r_word_in_blk <= r_word_in_blk + 9'd1;
                  end else if (r_blk == NMAX - 9'd1) begin
                    r_state       <= S_FULL;
                    r_word_in_blk <= r_word_in_blk + 9'd1;
                  end else begin
                    r_blk         <= r_blk + 9'd1;
                    r_word_in_blk <= 9'd0;
                  end
                end else begin
                  r_word_in_blk <= r_word_in_blk + 9'd1;
                end
              end
            end
            S_CRC0: begin
              if (INC) begin
                r_exp   <= w_word16;
                r_state <= S_CRC1;
              end
            end
            S_CRC1: begin
              if (INC) begin
                if (!w_crc_pass) begin
                  r_crc_err <= 1'b1;
                  if (r_err_blks != 4'd15) r_err_blks <= r_err_blks + 4'd1;
                end
                r_crc         <= 16'hFFFF;
                r_word_in_blk <= 9'd0;
                if (r_blk == NMAX - 9'd1) begin
                  r_state <= S_FULL;
                end else begin
                  r_blk   <= r_blk + 9'd1;
                  r_state <= S_DATA;
                end
              end
            end
            S_FULL, S_DONE: begin
              if (INC) r_ovf <= 1'b1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign WE        = r_we;
  assign WADDR     = r_waddr;
  assign WDATA     = r_wdata;
  assign LOAD_DONE = r_load_done;
  assign LOAD_OK   = r_load_ok;
  assign CRC_ERR   = r_crc_err;
  assign ERR_BLKS  = r_err_blks;
  assign OVF       = r_ovf;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_prom_word_loader.sv
module tb_prom_word_loader;

  localparam logic [8:0] MW = 9'd4;
  localparam logic [8:0] NB = 9'd2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  PROM_DATA;
  logic        LDB0, LDB1, LDB2, LDB3, LDB4, LDB5;
  logic        INC, RST_CNT, XFER_DONE, ECC, CRC;
  logic        WE;
  logic [8:0]  WADDR;
  logic [47:0] WDATA;
  logic        LOAD_DONE, LOAD_OK, CRC_ERR, OVF;
  logic [3:0]  ERR_BLKS;
  logic [2:0]  DBG_STATE;

  prom_word_loader #(.MAX_WRDS(MW), .NMAX(NB)) dut (
    .CLK(CLK), .RST(RST), .PROM_DATA(PROM_DATA),
    .LDB0(LDB0), .LDB1(LDB1), .LDB2(LDB2), .LDB3(LDB3), .LDB4(LDB4), .LDB5(LDB5),
    .INC(INC), .RST_CNT(RST_CNT), .XFER_DONE(XFER_DONE), .ECC(ECC), .CRC(CRC),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .LOAD_DONE(LOAD_DONE), .LOAD_OK(LOAD_OK),
    .CRC_ERR(CRC_ERR), .ERR_BLKS(ERR_BLKS), .OVF(OVF), .DBG_STATE(DBG_STATE)
  );

  // Clock
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [56:0] exp_q[$];
  logic [8:0]  exp_addr;
  logic [15:0] blk_data [0:3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference CRC-16-CCITT, byte-wise over the high then low byte.
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] x;
    logic [7:0]  by;
    x = c;
    for (int k = 0; k < 2; k++) begin
      by = (k == 0) ? w[15:8] : w[7:0];
      x  = x ^ {by, 8'h00};
      for (int j = 0; j < 8; j++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    end
    return x;
  endfunction

  // Scoreboard: every WE pulse must match the oldest expected write.
  always @(negedge CLK) begin
    logic [56:0] e;
    if (WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", 64'(WADDR), 64'h1FF);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 64'(WADDR), 64'(e[56:48]));
        check("wdata", 64'(WDATA), 64'(e[47:0]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ldb(input logic [5:0] m);
    {LDB5, LDB4, LDB3, LDB2, LDB1, LDB0} = m;
  endtask

  task automatic clear_inputs();
    set_ldb(6'd0);
    INC = 1'b0; PROM_DATA = 8'd0; RST_CNT = 1'b0; XFER_DONE = 1'b0; ECC = 1'b0; CRC = 1'b0;
  endtask

  task automatic drive_word(input logic [47:0] w, input logic ecc_m, input logic exp_wr);
    int nb;
    nb = ecc_m ? 6 : 2;
    if (exp_wr) begin
      exp_q.push_back({exp_addr, (ecc_m ? w : {32'd0, w[15:0]})});
      exp_addr++;
    end
    for (int i = 0; i < nb; i++) begin
      PROM_DATA = w[8*i +: 8];
      set_ldb(6'(1 << i));
      INC = (i == nb - 1);
      tick();
    end
    set_ldb(6'd0); INC = 1'b0; PROM_DATA = 8'd0;
  endtask

  task automatic start_xfer(input logic ecc_m, input logic crc_m);
    RST_CNT = 1'b1; ECC = ecc_m; CRC = crc_m;
    tick();
    RST_CNT = 1'b0; ECC = 1'b0; CRC = 1'b0;
    tick();
    exp_addr = 9'd0;
    @(negedge CLK);
    check("start_state", 64'(DBG_STATE), 64'd1);
    check("start_crc_err", 64'(CRC_ERR), 64'd0);
    check("start_err_blks", 64'(ERR_BLKS), 64'd0);
    check("start_ovf", 64'(OVF), 64'd0);
  endtask

  // XFER_DONE held two cycles: LOAD_DONE must pulse only for the first.
  task automatic finish_xfer(input logic exp_ok);
    tick();
    XFER_DONE = 1'b1;
    tick();
    @(negedge CLK);
    check("load_done_pulse", 64'(LOAD_DONE), 64'd1);
    check("load_ok", 64'(LOAD_OK), 64'(exp_ok));
    tick();
    XFER_DONE = 1'b0;
    @(negedge CLK);
    check("load_done_single", 64'(LOAD_DONE), 64'd0);
    check("done_state", 64'(DBG_STATE), 64'd5);
    check("q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic drive_crc_block(input logic [15:0] corrupt);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int j = 0; j < 4; j++) begin
      drive_word({32'd0, blk_data[j]}, 1'b0, 1'b1);
      c = crc_ref(c, blk_data[j]);
    end
    drive_word({32'd0, c}, 1'b0, 1'b0);
    drive_word({32'd0, (~c) ^ corrupt}, 1'b0, 1'b0);
  endtask

  initial begin
    logic [47:0] w;
    blk_data[0] = 16'h1234; blk_data[1] = 16'h5678;
    blk_data[2] = 16'h9ABC; blk_data[3] = 16'hDEF0;
    exp_addr = 9'd0;
    clear_inputs();
    RST = 1'b1;

    // Reset values
    @(negedge CLK);
    check("rst_we", 64'(WE), 64'd0);
    check("rst_waddr", 64'(WADDR), 64'd0);
    check("rst_wdata", 64'(WDATA), 64'd0);
    check("rst_load_ok", 64'(LOAD_OK), 64'd0);
    check("rst_state", 64'(DBG_STATE), 64'd0);
    tick();
    RST = 1'b0;
    tick();

    // 1: 16-bit words, no CRC
    start_xfer(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) drive_word({32'd0, 8'(2*k + 2), 8'(2*k + 1)}, 1'b0, 1'b1);
    @(negedge CLK);
    check("t1_full_state", 64'(DBG_STATE), 64'd4);
    finish_xfer(1'b1);

    // 2: 48-bit ECC words
    start_xfer(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 6; i++) w[8*i +: 8] = 8'(8'h10 + 6*k + i);
      drive_word(w, 1'b1, 1'b1);
    end
    finish_xfer(1'b1);

    // 4: CRC mode, block 1 complement word has one bit flipped
    start_xfer(1'b0, 1'b1);
    drive_crc_block(16'h0000);
    @(negedge CLK);
    check("t4_crc_err_blk0", 64'(CRC_ERR), 64'd0);
    drive_crc_block(16'h0001);
    @(negedge CLK);
    check("t4_crc_err", 64'(CRC_ERR), 64'd1);
    check("t4_err_blks", 64'(ERR_BLKS), 64'd1);
    finish_xfer(1'b0);

    // 5a: early XFER_DONE after 5 of 8 words
    start_xfer(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) drive_word({32'd0, 16'($urandom_range(0, 65535))}, 1'b0, 1'b1);
    finish_xfer(1'b0);

    // 5b: extra INC after a full load
    start_xfer(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) drive_word({32'd0, 16'($urandom_range(0, 65535))}, 1'b0, 1'b1);
    @(negedge CLK);
    check("t5_ovf_before", 64'(OVF), 64'd0);
    drive_word({32'd0, 16'hCAFE}, 1'b0, 1'b0);
    @(negedge CLK);
    check("t5_ovf", 64'(OVF), 64'd1);
    finish_xfer(1'b0);

    // 3: CRC mode, correct CRC words (also clears the earlier CRC_ERR)
    start_xfer(1'b0, 1'b1);
    drive_crc_block(16'h0000);
    drive_crc_block(16'h0000);
    @(negedge CLK);
    check("t3_crc_err", 64'(CRC_ERR), 64'd0);
    check("t3_err_blks", 64'(ERR_BLKS), 64'd0);
    finish_xfer(1'b1);

    // 6: RST_CNT together with INC, then RST in the middle of word 3
    start_xfer(1'b0, 1'b0);
    drive_word({32'd0, 16'h1111}, 1'b0, 1'b1);
    PROM_DATA = 8'hAA; set_ldb(6'b000001);
    tick();
    PROM_DATA = 8'hBB; set_ldb(6'b000010); INC = 1'b1; RST_CNT = 1'b1;
    tick();
    set_ldb(6'd0); INC = 1'b0; RST_CNT = 1'b0; PROM_DATA = 8'd0;
    tick();
    exp_addr = 9'd0;
    @(negedge CLK);
    check("t6_state_after_clr", 64'(DBG_STATE), 64'd1);
    drive_word({32'd0, 16'h2222}, 1'b0, 1'b1);
    drive_word({32'd0, 16'h3333}, 1'b0, 1'b1);
    drive_word({32'd0, 16'h4444}, 1'b0, 1'b1);
    PROM_DATA = 8'h55; set_ldb(6'b000001);
    tick();
    #2;
    RST = 1'b1;
    #1;
    check("t6_arst_we", 64'(WE), 64'd0);
    check("t6_arst_waddr", 64'(WADDR), 64'd0);
    check("t6_arst_wdata", 64'(WDATA), 64'd0);
    check("t6_arst_load_ok", 64'(LOAD_OK), 64'd0);
    check("t6_arst_state", 64'(DBG_STATE), 64'd0);
    PROM_DATA = 8'h66; set_ldb(6'b000010); INC = 1'b1; XFER_DONE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("t6_rst_load_done", 64'(LOAD_DONE), 64'd0);
      check("t6_rst_we", 64'(WE), 64'd0);
    end
    tick();
    clear_inputs();
    RST = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    check("t6_load_done_after", 64'(LOAD_DONE), 64'd0);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/prom_word_loader.md
# prom_word_loader

Downstream consumer of the PROM transfer sequencer. It captures PROM bytes on the sequencer's byte-load strobes and assembles them into 16-bit words, or 48-bit words when ECC is set. In CRC mode it checks a per-block CRC-16. It writes the data words into the downstream configuration memory, then reports load completion and status when the sequencer signals transfer done.

## Interface
Parameters:
- MAX_WRDS, 9'd34: data words per block; must match the sequencer.
- NMAX, 9'd10: blocks per transfer.

Ports:
- CLK, input, 1: single clock for all logic.
- RST, input, 1: asynchronous, active-high reset.
- PROM_DATA, input, 8: PROM byte bus; valid in every cycle in which an LDBn strobe is high.
- LDB0..LDB5, input, 1 each: byte-lane load strobes from the sequencer.
- INC, input, 1: high in the cycle of the last byte of a word (the LDB1 cycle when ECC=0, the LDB5 cycle when ECC=1).
- RST_CNT, input, 1: start-of-transfer clear from the sequencer.
- XFER_DONE, input, 1: transfer complete from the sequencer.
- ECC, input, 1: word-format select; sampled only while RST_CNT=1.
- CRC, input, 1: CRC-mode select; sampled only while RST_CNT=1.
- WE, output, 1: memory write strobe, one cycle wide.
- WADDR, output, 9: data-word address.
- WDATA, output, 48: {B5,B4,B3,B2,B1,B0}; bits 47:16 are zero when ECC=0.
- LOAD_DONE, output, 1: one-cycle pulse on the first XFER_DONE cycle.
- LOAD_OK, output, 1: level; 1 when the last load had the correct word count, no CRC error and no overflow.
- CRC_ERR, output, 1: sticky; set when any block fails its CRC check.
- ERR_BLKS, output, 4: saturating count of blocks that failed CRC.
- OVF, output, 1: sticky; set when an INC arrives after the final expected word.

## Operation
- State machine: IDLE, DATA, CRC0, CRC1, FULL, DONE.
- RST_CNT=1 from any state:
  - Go to IDLE.
  - Latch the ECC and CRC mode bits.
  - Clear the byte registers, word_in_blk, blk, waddr, crc (set to 16'hFFFF), CRC_ERR, ERR_BLKS and OVF.
  - LOAD_OK is not changed.
  - RST_CNT takes priority over a simultaneous INC or LDBn.
- Byte capture: on each edge where LDBn=1, Bn <= PROM_DATA. More than one strobe high at once is legal; each lane captures independently.
- Word assembly: on each edge where INC=1, the word is the stored bytes with the current lane's byte taken from PROM_DATA, so there is no extra cycle.
- IDLE: when RST_CNT drops, go to DATA.
- DATA, on INC:
  - Write the word.
  - Update crc with CRC-16-CCITT (poly 0x1021, MSB-first, 16 bits per cycle) over word[15:0]; bytes B2..B5 are not covered.
  - waddr++ and word_in_blk++.
  - When word_in_blk reaches MAX_WRDS-1: if CRC mode, go to CRC0; otherwise, when blk reaches NMAX-1, go to FULL, else blk++ and word_in_blk=0.
- CRC0, on INC: no write. Hold word[15:0] as exp, then go to CRC1.
- CRC1, on INC: no write.
  - Pass condition: exp==crc and word[15:0]==~crc.
  - On fail: CRC_ERR=1 and ERR_BLKS++ (saturates at 15).
  - Then crc=16'hFFFF and word_in_blk=0.
  - If blk==NMAX-1, go to FULL; else blk++ and go to DATA.
- FULL: a further INC sets OVF and causes no write.
- XFER_DONE=1 in any state other than DONE:
  - Go to DONE.
  - LOAD_DONE pulses.
  - LOAD_OK = (state==FULL) & ~CRC_ERR & ~OVF.
  - An early XFER_DONE (state is DATA, CRC0 or CRC1) therefore gives LOAD_OK=0.
- DONE: hold until RST_CNT. An INC in DONE sets OVF and causes no write.

## Timing
- WE, WADDR and WDATA are registered and appear in the cycle after the INC cycle, held for one cycle.
- WADDR runs from 0 to NMAX*MAX_WRDS-1 in both modes, because CRC words take no address.
- CRC_ERR and ERR_BLKS update in the cycle after the CRC1 INC.
- LOAD_DONE and LOAD_OK update in the cycle after the first XFER_DONE cycle.
- The minimum INC spacing is 2 cycles (sequencer Byte0/Byte1 loop); the block sustains this rate with no stall.
- Reset values:
  - All outputs 0, including LOAD_OK=0.
  - State IDLE, crc=16'hFFFF, byte registers 0.
- RST mid-transfer aborts immediately, with no write and no LOAD_DONE.

## Test plan
1. **ECC=0, CRC=0, MAX_WRDS=4, NMAX=2.** Stimulus: 8 words of bytes 0x01,0x02 and so on, then XFER_DONE. Response: 8 WE pulses at WADDR 0..7 with WDATA=16'h0201, 16'h0403 and so on; LOAD_DONE pulses; LOAD_OK=1.
2. **ECC=1, same sizes.** Stimulus: 6 bytes per word, 0x10..0x15. Response: the first WDATA is 48'h151413121110, with INC accepted in the LDB5 cycle.
3. **CRC=1, correct CRC words.** Stimulus: data 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 per block, followed by the correct CRC and its complement. Response: 8 writes only, CRC_ERR=0, LOAD_OK=1.
4. **CRC=1, corrupted block 1.** Stimulus: block 1's complement word corrupted by one bit. Response: CRC_ERR=1 one cycle after that INC; ERR_BLKS=1; LOAD_OK=0.
5. **Early and extra INC.** Stimulus: XFER_DONE after 5 of 8 words. Response: LOAD_OK=0. Separately, a 9th INC after a full load sets OVF, causes no WE, and gives LOAD_OK=0.
6. **Simultaneous events.** Stimulus: RST_CNT and INC in the same cycle. Response: no write, counters zeroed. Then assert RST during word 3. Response: all outputs go to 0 asynchronously and no LOAD_DONE pulse occurs.
